// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory stage of the 5-stage MIPS pipeline, between EX/MEM and PipeMtoW.
//   Issues loads/stores on a variable-latency req/ack data bus, builds byte
//   enables and lane-replicated store data, formats load data (byte/half/word,
//   signed/unsigned), and stalls the pipeline until the access completes.
//
// Parameters
//   TIMEOUT     cycles spent in REQ without mem_ack before the access is
//               aborted with a bus error (1..65535)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   validM                      instruction present (0 = bubble)
//   ALUOutMi/WriteDataM         effective address / store data
//   WriteRegMi/RegWriteMi       destination register / write enable
//   MemtoRegMi/MemWriteM        load / store flags
//   MemSizeM/MemSignedM         access size (00 b, 01 h, 1x w) / load sign
//   mem_req/mem_we/mem_addr/
//   mem_be/mem_wdata            data-memory request side (req/we/be/wdata
//                               registered)
//   mem_ack/mem_rdata           one-cycle completion pulse with read data
//   ALUOutM/ReadDataM/WriteRegM/
//   RegWriteM/MemtoRegM         values handed to PipeMtoW
//   StallM                      hold F/D/E/M and clear PipeMtoW
//   misalignM                   pulse: misaligned access, no bus request
//   bus_errM                    high in the DONE cycle of a timed-out access
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validM,
  input  logic [31:0] ALUOutMi,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegMi,
  input  logic        RegWriteMi,
  input  logic        MemtoRegMi,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        StallM,
  output logic        misalignM,
  output logic        bus_errM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_err_q, bus_err_d;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic        memop;
  logic        is_byte, is_half, is_word;
  logic        misaligned;
  logic [1:0]  boff;

  assign memop   = validM & (MemtoRegMi | MemWriteM);
  assign boff    = ALUOutMi[1:0];
  assign is_byte = (MemSizeM == 2'b00);
  assign is_half = (MemSizeM == 2'b01);
  assign is_word = MemSizeM[1];  // 11 behaves as word

  assign misaligned = (is_half & boff[0]) | (is_word & (boff != 2'b00));

  // Per-lane decode of the byte offset and read-data lane split.
  logic [3:0] lane_sel;
  logic [7:0] rd_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_sel[gi] = (boff == 2'(gi));
    assign rd_lane[gi]  = mem_rdata[8*gi +: 8];
  end

  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteDataM;
    if (is_byte) begin
      be_calc    = lane_sel;
      wdata_calc = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      be_calc    = boff[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{WriteDataM[15:0]}};
    end
  end

  always_comb begin
    rd_byte  = rd_lane[boff];
    rd_half  = boff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt = mem_rdata;
    if (is_byte) begin
      load_fmt = {{24{MemSignedM & rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      load_fmt = {{16{MemSignedM & rd_half[15]}}, rd_half};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;
    tmo_cnt_d   = tmo_cnt_q;
    bus_err_d   = 1'b0;
    StallM      = 1'b0;
    misalignM   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (memop) begin
          if (misaligned) begin
            // Rejected on the spot: no bus traffic, pipeline keeps moving.
            misalignM = 1'b1;
          end else begin
            StallM      = 1'b1;
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWriteM;
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
          end
        end
      end

      S_REQ: begin
        StallM = 1'b1;
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (!MemWriteM) begin
            read_data_d = load_fmt;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          bus_err_d = 1'b1;
          if (!MemWriteM) begin
            read_data_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      // The pipeline advances out of this cycle; the instruction still on the
      // inputs is the one just completed and must not be issued again.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        mem_be_d  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      read_data_q <= '0;
      tmo_cnt_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = {ALUOutMi[31:2], 2'b00};

  assign ALUOutM   = ALUOutMi;
  assign ReadDataM = read_data_q;
  assign WriteRegM = WriteRegMi;
  assign MemtoRegM = MemtoRegMi & validM;
  assign bus_errM  = bus_err_q;
  assign RegWriteM = RegWriteMi & validM & ~(misalignM | bus_errM);

endmodule
